// File: rtl/mux_ps_pkg.sv
// Shared types and helpers for the DDC parallel-to-serial multiplexer.
// Optional frame-aligned scheduling is selected with MUX_PS_FRAME_ALIGN_EN.
package mux_ps_pkg;

   typedef enum logic [1:0] {SCAN, PRESENT, GAP} state_t;

   localparam int CHIDX_INVALID = 0;

   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mux_ps_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest word while not empty.
// Occupancy is counted explicitly so full/empty/level come straight from one register.
module mux_ps_fifo
   import mux_ps_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr,
   input  logic                          rd,
   input  logic [DATA_WIDTH-1:0]         din,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          empty,
   output logic                          full,
   output logic [level_w(FIFO_DEPTH)-1:0] level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = level_w(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         count_q;
   logic                  wr_en, rd_en;

   // A write into a full FIFO is refused even if a read frees a slot on the same edge.
   assign wr_en = wr && !full;
   assign rd_en = rd && !empty;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + LW'(wr_en) - LW'(rd_en);
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == LW'(FIFO_DEPTH));
   assign level = count_q;

endmodule

// File: rtl/ddc_mux_ps_nch.sv
// N-channel FIFO-buffered round-robin serialiser with tagged valid/ready output.
// Define MUX_PS_FRAME_ALIGN_EN for strict 0..N-1 frames and a Data_Out_Sof output.
module ddc_mux_ps_nch
   import mux_ps_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int DATA_WIDTH  = 24,
   parameter int FIFO_DEPTH  = 16,
   parameter int SLOT_CLKS   = 8,
   parameter int CHIDX_WIDTH = 4
) (
   input  logic                                    CLK,
   input  logic                                    nRST,
   input  logic [NUM_CH*DATA_WIDTH-1:0]            Data_In,
   input  logic [NUM_CH-1:0]                       Data_In_Valid,
   output logic [DATA_WIDTH-1:0]                   Data_Out,
   output logic                                    Data_Out_Valid,
   input  logic                                    Data_Out_Ready,
   output logic [CHIDX_WIDTH-1:0]                  Data_Out_ChIdx,
   output logic [NUM_CH-1:0]                       Overflow,
`ifdef MUX_PS_FRAME_ALIGN_EN
   output logic                                    Data_Out_Sof,
`endif
   output logic [NUM_CH*level_w(FIFO_DEPTH)-1:0]   Fifo_Level
);

   localparam int LW    = level_w(FIFO_DEPTH);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int GAP_W = $clog2(SLOT_CLKS + 1);

   logic [DATA_WIDTH-1:0]  fifo_dout [NUM_CH];
   logic [NUM_CH-1:0]      empty, full, rd;
   logic                   pick;
   logic [CH_W-1:0]        pick_ch;

   state_t                 state_q;
   logic [DATA_WIDTH-1:0]  data_q;
   logic                   valid_q;
   logic [CHIDX_WIDTH-1:0] chidx_q;
   logic [CH_W-1:0]        cur_ch_q;
   logic [GAP_W-1:0]       gap_q;
   logic [NUM_CH-1:0]      overflow_q;
   logic [CH_W-1:0]        next_ch;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign rd[gi] = (state_q == SCAN) && pick && (pick_ch == CH_W'(gi));
         mux_ps_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (CLK),
            .rst_n (nRST),
            .wr    (Data_In_Valid[gi]),
            .rd    (rd[gi]),
            .din   (Data_In[gi*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (fifo_dout[gi]),
            .empty (empty[gi]),
            .full  (full[gi]),
            .level (Fifo_Level[gi*LW +: LW])
         );
      end
   endgenerate

   assign next_ch = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;

`ifdef MUX_PS_FRAME_ALIGN_EN
   logic            frame_act_q;
   logic [CH_W-1:0] frame_idx_q;
   logic            sof_q;

   // Inside a frame the next channel is fixed; a new frame needs every FIFO loaded.
   always_comb begin
      pick    = 1'b0;
      pick_ch = frame_idx_q;
      if (frame_act_q) begin
         pick = !empty[frame_idx_q];
      end else if (&(~empty)) begin
         pick    = 1'b1;
         pick_ch = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         frame_act_q <= 1'b0;
         frame_idx_q <= '0;
         sof_q       <= 1'b0;
      end else if (state_q == SCAN && pick) begin
         frame_act_q <= 1'b1;
         sof_q       <= !frame_act_q;
      end else if (state_q == PRESENT && Data_Out_Ready) begin
         sof_q       <= 1'b0;
         frame_act_q <= (cur_ch_q != CH_W'(NUM_CH - 1));
         frame_idx_q <= next_ch;
      end
   end

   assign Data_Out_Sof = sof_q;
`else
   logic [CH_W-1:0] rr_ptr_q;

   // Walk backwards so the channel closest to rr_ptr is the one left selected.
   always_comb begin
      int c;
      pick    = 1'b0;
      pick_ch = '0;
      c       = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         c = int'(rr_ptr_q) + i;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!empty[CH_W'(c)]) begin
            pick    = 1'b1;
            pick_ch = CH_W'(c);
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rr_ptr_q <= '0;
      end else if (state_q == PRESENT && Data_Out_Ready) begin
         rr_ptr_q <= next_ch;
      end
   end
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= SCAN;
         data_q   <= '0;
         valid_q  <= 1'b0;
         chidx_q  <= CHIDX_WIDTH'(CHIDX_INVALID);
         cur_ch_q <= '0;
         gap_q    <= '0;
      end else begin
         case (state_q)
            SCAN: begin
               if (pick) begin
                  data_q   <= fifo_dout[pick_ch];
                  chidx_q  <= CHIDX_WIDTH'(pick_ch) + 1'b1;
                  valid_q  <= 1'b1;
                  cur_ch_q <= pick_ch;
                  state_q  <= PRESENT;
               end
            end
            PRESENT: begin
               if (Data_Out_Ready) begin
                  valid_q <= 1'b0;
                  chidx_q <= CHIDX_WIDTH'(CHIDX_INVALID);
                  gap_q   <= GAP_W'(SLOT_CLKS - 1);
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (gap_q == '0) state_q <= SCAN;
               else             gap_q   <= gap_q - 1'b1;
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) overflow_q <= '0;
      else       overflow_q <= overflow_q | (Data_In_Valid & full);
   end

   assign Data_Out       = data_q;
   assign Data_Out_Valid = valid_q;
   assign Data_Out_ChIdx = chidx_q;
   assign Overflow       = overflow_q;

endmodule

// File: tb/tb_ddc_mux_ps_nch.sv
// Directed bench for ddc_mux_ps_nch (4 channels, default build without MUX_PS_FRAME_ALIGN_EN).
// A queue-based model is compared every cycle; directed sections pin literal values.
module tb_ddc_mux_ps_nch;

   localparam int NCH  = 4;
   localparam int DW   = 24;
   localparam int DEP  = 16;
   localparam int SLOT = 8;
   localparam int CIW  = 4;
   localparam int LW   = $clog2(DEP) + 1;

   logic                clk = 1'b0;
   logic                nRST = 1'b0;
   logic [NCH*DW-1:0]   Data_In = '0;
   logic [NCH-1:0]      Data_In_Valid = '0;
   logic [DW-1:0]       Data_Out;
   logic                Data_Out_Valid;
   logic                Data_Out_Ready = 1'b1;
   logic [CIW-1:0]      Data_Out_ChIdx;
   logic [NCH-1:0]      Overflow;
   logic [NCH*LW-1:0]   Fifo_Level;
`ifdef MUX_PS_FRAME_ALIGN_EN
   logic                Data_Out_Sof;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int edge_cnt = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   ddc_mux_ps_nch #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .SLOT_CLKS(SLOT), .CHIDX_WIDTH(CIW)
   ) dut (
      .CLK(clk), .nRST(nRST), .Data_In(Data_In), .Data_In_Valid(Data_In_Valid),
      .Data_Out(Data_Out), .Data_Out_Valid(Data_Out_Valid), .Data_Out_Ready(Data_Out_Ready),
      .Data_Out_ChIdx(Data_Out_ChIdx), .Overflow(Overflow),
`ifdef MUX_PS_FRAME_ALIGN_EN
      .Data_Out_Sof(Data_Out_Sof),
`endif
      .Fifo_Level(Fifo_Level)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Model: per-channel queues, one presented item, and the earliest cycle a new pick may happen.
   logic [DW-1:0]  m_q [NCH][$];
   bit             m_pres;
   int             m_ch, m_rr, m_cyc, m_next_sel;
   logic [DW-1:0]  m_last;
   logic [NCH-1:0] m_ovf;
   int             m_pre_sz [NCH];

   always @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         for (int c = 0; c < NCH; c++) m_q[c].delete();
         m_pres = 1'b0; m_ch = 0; m_rr = 0; m_cyc = 0; m_next_sel = 0;
         m_last = '0; m_ovf = '0;
      end else begin
         m_cyc++;
         for (int c = 0; c < NCH; c++) m_pre_sz[c] = m_q[c].size();
         if (m_pres) begin
            if (Data_Out_Ready) begin
               m_pres     = 1'b0;
               m_rr       = (m_ch + 1) % NCH;
               m_next_sel = m_cyc + SLOT + 1;
            end
         end else if (m_cyc >= m_next_sel) begin
            for (int i = 0; i < NCH; i++) begin
               int c;
               c = (m_rr + i) % NCH;
               if (m_q[c].size() > 0) begin
                  m_ch   = c;
                  m_last = m_q[c].pop_front();
                  m_pres = 1'b1;
                  break;
               end
            end
         end
         for (int c = 0; c < NCH; c++) begin
            if (Data_In_Valid[c]) begin
               if (m_pre_sz[c] >= DEP) m_ovf[c] = 1'b1;
               else                    m_q[c].push_back(Data_In[c*DW +: DW]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [NCH*LW-1:0] lvl;
         lvl = '0;
         for (int c = 0; c < NCH; c++) lvl[c*LW +: LW] = LW'(m_q[c].size());
         chk("cyc_valid",    64'(Data_Out_Valid), 64'(m_pres));
         chk("cyc_chidx",    64'(Data_Out_ChIdx), m_pres ? 64'(m_ch + 1) : 64'd0);
         chk("cyc_data",     64'(Data_Out),       64'(m_last));
         chk("cyc_overflow", 64'(Overflow),       64'(m_ovf));
         chk("cyc_level",    64'(Fifo_Level),     64'(lvl));
      end
   end

   // Output handshakes as observed at the consumer.
   int            o_ch [$];
   logic [DW-1:0] o_dat [$];
   int            o_cyc [$];

   always @(negedge clk) begin
      if (nRST && Data_Out_Valid && Data_Out_Ready) begin
         o_ch.push_back(int'(Data_Out_ChIdx));
         o_dat.push_back(Data_Out);
         o_cyc.push_back(edge_cnt);
         $display("xfer: cycle %0d chidx %0d data 0x%06h", edge_cnt, Data_Out_ChIdx, Data_Out);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr1(input int ch, input logic [DW-1:0] d);
      Data_In[ch*DW +: DW] = d;
      Data_In_Valid[ch]    = 1'b1;
      tick();
      Data_In_Valid        = '0;
   endtask

   task automatic expect_out(input string name, input int ch, input logic [DW-1:0] d, output int cyc);
      int waited;
      waited = 0;
      cyc    = -1;
      while (o_ch.size() == 0 && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (o_ch.size() == 0) begin
         chk({name, "_timeout"}, 64'd0, 64'd1);
      end else begin
         chk({name, "_ch"},   64'(o_ch.pop_front()), 64'(ch));
         chk({name, "_data"}, 64'(o_dat.pop_front()), 64'(d));
         cyc = o_cyc.pop_front();
      end
   endtask

   initial begin
      int p, c1, c2, cx;

      // Reset and idle
      tick(5);
      cmp_en = 1'b1;
      nRST   = 1'b1;
      tick(50);
      chk("idle_valid", 64'(Data_Out_Valid), 64'd0);
      chk("idle_chidx", 64'(Data_Out_ChIdx), 64'd0);
      chk("idle_ovf",   64'(Overflow),       64'd0);

      // Basic order, latency and slot spacing
      p = edge_cnt;
      Data_In[0*DW +: DW] = 24'h000011;
      Data_In[1*DW +: DW] = 24'hFFFFEE;
      Data_In_Valid = 4'b0011;
      tick();
      Data_In_Valid = '0;
      expect_out("basic0", 1, 24'h000011, c1);
      expect_out("basic1", 2, 24'hFFFFEE, c2);
      chk("basic_latency", 64'(c1 - p), 64'd2);
      chk("basic_spacing", 64'(c2 - c1), 64'(SLOT + 2));
      tick(15);

      // Backpressure: first sample held stable, then all three in order
      Data_Out_Ready = 1'b0;
      wr1(0, 24'hA00001);
      wr1(0, 24'hA00002);
      wr1(0, 24'hA00003);
      repeat (20) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(Data_Out_Valid), 64'd1);
         chk("bp_hold_data",  64'(Data_Out),       64'hA00001);
      end
      tick();
      Data_Out_Ready = 1'b1;
      expect_out("bp0", 1, 24'hA00001, cx);
      expect_out("bp1", 1, 24'hA00002, cx);
      expect_out("bp2", 1, 24'hA00003, cx);
      tick(15);

      // Overflow: park a ch0 sample, then push 17 into ch1
      Data_Out_Ready = 1'b0;
      wr1(0, 24'h0000C0);
      tick(3);
      for (int i = 1; i <= 17; i++) wr1(1, DW'(24'h000100 + i));
      tick();
      chk("ovf_flags", 64'(Overflow), 64'b0010);
      chk("ovf_level", 64'(Fifo_Level[1*LW +: LW]), 64'd16);
      Data_Out_Ready = 1'b1;
      expect_out("ovf_park", 1, 24'h0000C0, cx);
      for (int i = 1; i <= 16; i++) expect_out("ovf_seq", 2, DW'(24'h000100 + i), cx);
      tick(40);
      chk("ovf_17th_absent", 64'(o_ch.size()), 64'd0);
      chk("ovf_sticky", 64'(Overflow), 64'b0010);

      // Fairness: ch2 backlog, one ch0 sample slips in after the first ch2 output
      Data_Out_Ready = 1'b0;
      for (int i = 1; i <= 8; i++) wr1(2, DW'(24'h000200 + i));
      wr1(0, 24'h0000AA);
      tick();
      Data_Out_Ready = 1'b1;
      expect_out("fair0", 3, 24'h000201, cx);
      expect_out("fair1", 1, 24'h0000AA, cx);
      for (int i = 2; i <= 8; i++) expect_out("fair_rest", 3, DW'(24'h000200 + i), cx);
      tick(15);

      // Reset mid-operation discards everything
      Data_Out_Ready = 1'b0;
      wr1(3, 24'h00D001);
      wr1(3, 24'h00D002);
      wr1(3, 24'h00D003);
      tick(2);
      nRST = 1'b0;
      tick(3);
      chk("rst_valid", 64'(Data_Out_Valid), 64'd0);
      chk("rst_level", 64'(Fifo_Level),     64'd0);
      chk("rst_ovf",   64'(Overflow),       64'd0);
      chk("rst_data",  64'(Data_Out),       64'd0);
      o_ch.delete(); o_dat.delete(); o_cyc.delete();
      nRST = 1'b1;
      Data_Out_Ready = 1'b1;
      tick(30);
      chk("rst_no_output", 64'(o_ch.size()), 64'd0);

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
